// File: rtl/vip_matrix_generate_nxn_if.sv
// Video stream bundle for the K x K window generator: raster input side plus delayed window output side.
// Define VIP_MATRIX_FULL_FLAG_EN to carry matrix_full alongside the window.
interface vip_matrix_generate_nxn_if #(
   parameter int DATA_W = 8,
   parameter int KSIZE  = 3
);
   logic                            pre_frame_vsync;
   logic                            pre_frame_href;
   logic                            pre_frame_clken;
   logic [DATA_W-1:0]               pre_img_data;
   logic                            matrix_frame_vsync;
   logic                            matrix_frame_href;
   logic                            matrix_frame_clken;
   logic [KSIZE*KSIZE*DATA_W-1:0]   matrix_data;
`ifdef VIP_MATRIX_FULL_FLAG_EN
   logic                            matrix_full;
`endif

   modport master (
      output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_data,
      input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_data
`ifdef VIP_MATRIX_FULL_FLAG_EN
      , input matrix_full
`endif
   );

   modport slave (
      input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_data,
      output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_data
`ifdef VIP_MATRIX_FULL_FLAG_EN
      , output matrix_full
`endif
   );
endinterface

// File: rtl/vip_matrix_generate_nxn.sv
// K x K sliding-window generator over K-1 inferred line buffers; fixed 3-cycle latency, no backpressure.
// Define VIP_MATRIX_FULL_FLAG_EN to add matrix_full (window lies entirely inside the image).
module vip_matrix_generate_nxn #(
   parameter int DATA_W    = 8,
   parameter int KSIZE     = 3,
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int PAD_MODE  = 0
) (
   input logic                  clk,
   input logic                  rst,
   vip_matrix_generate_nxn_if.slave bus
);
   localparam int XW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
   localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
   localparam logic [XW-1:0] X_MAX = XW'(IMG_HDISP - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_VDISP - 1);

   generate
      if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
         $fatal(1, "vip_matrix_generate_nxn: KSIZE must be 3 or 5");
      end
   endgenerate

   logic            vs_q, hr_q, x_ovf;
   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt, y_cur;
   logic            vs_rise, hr_fall, acc;

   assign vs_rise = bus.pre_frame_vsync & ~vs_q;
   assign hr_fall = hr_q & ~bus.pre_frame_href;
   assign acc     = bus.pre_frame_href & bus.pre_frame_clken;
   // A line starting on the vsync edge already belongs to the new frame.
   assign y_cur   = vs_rise ? '0 : y_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q  <= 1'b0;
         hr_q  <= 1'b0;
         x_cnt <= '0;
         x_ovf <= 1'b0;
         y_cnt <= '0;
      end else begin
         vs_q <= bus.pre_frame_vsync;
         hr_q <= bus.pre_frame_href;
         if (hr_fall) begin
            x_cnt <= '0;
            x_ovf <= 1'b0;
         end else if (acc) begin
            if (x_cnt == X_MAX) x_ovf <= 1'b1;
            else                x_cnt <= x_cnt + 1'b1;
         end
         if (vs_rise)                      y_cnt <= '0;
         else if (hr_fall && y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
      end
   end

   // rd[0] holds line y-1, rd[K-2] holds line y-(K-1); each RAM passes its old word down.
   logic [KSIZE-2:0][DATA_W-1:0] rd;
   genvar gi;
   for (gi = 0; gi < KSIZE-1; gi++) begin : g_line
      logic [DATA_W-1:0] mem [IMG_HDISP];
      logic [DATA_W-1:0] wr;
      if (gi == 0) begin : g_first
         assign wr = bus.pre_img_data;
      end else begin : g_next
         assign wr = rd[gi-1];
      end
      assign rd[gi] = mem[x_cnt];
      always_ff @(posedge clk) begin
         if (acc && !x_ovf) mem[x_cnt] <= wr;
      end
   end

   logic [2:0]                               vs_dl, hr_dl, ce_dl;
   logic [KSIZE-1:0][DATA_W-1:0]             s1_col;
   logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0]  win;
   logic [XW-1:0]                            s1_x, s2_x;
   logic [YW-1:0]                            s1_y, s2_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_dl  <= '0;
         hr_dl  <= '0;
         ce_dl  <= '0;
         s1_col <= '0;
         s1_x   <= '0;
         s1_y   <= '0;
         win    <= '0;
         s2_x   <= '0;
         s2_y   <= '0;
      end else begin
         vs_dl <= {vs_dl[1:0], bus.pre_frame_vsync};
         hr_dl <= {hr_dl[1:0], bus.pre_frame_href};
         ce_dl <= {ce_dl[1:0], bus.pre_frame_clken};
         if (acc) begin
            for (int r = 0; r < KSIZE-1; r++) s1_col[r] <= rd[KSIZE-2-r];
            s1_col[KSIZE-1] <= bus.pre_img_data;
            s1_x <= x_cnt;
            s1_y <= y_cur;
         end
         if (hr_dl[0] && ce_dl[0]) begin
            for (int r = 0; r < KSIZE; r++) begin
               for (int c = 0; c < KSIZE-1; c++) win[r][c] <= win[r][c+1];
               win[r][KSIZE-1] <= s1_col[r];
            end
            s2_x <= s1_x;
            s2_y <= s1_y;
         end
      end
   end

   // Out-of-range rows/columns either read as zero or are redirected to the first valid one.
   logic [KSIZE-1:0] row_oor, col_oor;
   int               src_row [KSIZE];
   int               src_col [KSIZE];
   logic [KSIZE*KSIZE*DATA_W-1:0] pad_win;

   always_comb begin
      row_oor = '0;
      col_oor = '0;
      src_row = '{default: 0};
      src_col = '{default: 0};
      for (int k = 0; k < KSIZE; k++) begin
         row_oor[k] = (int'(s2_y) + k) < (KSIZE - 1);
         col_oor[k] = (int'(s2_x) + k) < (KSIZE - 1);
         src_row[k] = row_oor[k] ? (KSIZE - 1 - int'(s2_y)) : k;
         src_col[k] = col_oor[k] ? (KSIZE - 1 - int'(s2_x)) : k;
      end
   end

   always_comb begin
      pad_win = '0;
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            for (int i = 0; i < KSIZE; i++)
               for (int j = 0; j < KSIZE; j++)
                  if (!(PAD_MODE == 0 && (row_oor[r] || col_oor[c])) &&
                      i == src_row[r] && j == src_col[c])
                     pad_win[(r*KSIZE+c)*DATA_W +: DATA_W] = win[i][j];
   end

   logic [KSIZE*KSIZE*DATA_W-1:0] mdat;
   always_ff @(posedge clk) begin
      if (rst)                          mdat <= '0;
      else if (hr_dl[1] && ce_dl[1])    mdat <= pad_win;
      else if (!hr_dl[1])               mdat <= '0;
   end

   assign bus.matrix_frame_vsync = vs_dl[2];
   assign bus.matrix_frame_href  = hr_dl[2];
   assign bus.matrix_frame_clken = ce_dl[2];
   assign bus.matrix_data        = mdat;

`ifdef VIP_MATRIX_FULL_FLAG_EN
   logic full_q;
   always_ff @(posedge clk) begin
      if (rst) full_q <= 1'b0;
      else     full_q <= hr_dl[1] && ce_dl[1] &&
                         int'(s2_y) >= KSIZE - 1 && int'(s2_x) >= KSIZE - 1;
   end
   assign bus.matrix_full = full_q;
`endif
endmodule

// File: tb/tb_vip_matrix_generate_nxn.sv
// Directed bench: three generators (3x3 zero pad, 3x3 replicate, 5x5 10-bit) share one 8x6 raster.
`timescale 1ns/1ps
module tb_vip_matrix_generate_nxn;
   localparam int HD = 8, VD = 6, NCYC = 2048;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nchk = 0, nfail = 0;
   int   pc [VD][HD];
   int   vs_cyc, st0, st1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vip_matrix_generate_nxn_if #(.DATA_W(8),  .KSIZE(3)) if0 ();
   vip_matrix_generate_nxn_if #(.DATA_W(8),  .KSIZE(3)) if1 ();
   vip_matrix_generate_nxn_if #(.DATA_W(10), .KSIZE(5)) if2 ();

   vip_matrix_generate_nxn #(.DATA_W(8), .KSIZE(3), .IMG_HDISP(HD), .IMG_VDISP(VD), .PAD_MODE(0))
      u0 (.clk(clk), .rst(rst), .bus(if0));
   vip_matrix_generate_nxn #(.DATA_W(8), .KSIZE(3), .IMG_HDISP(HD), .IMG_VDISP(VD), .PAD_MODE(1))
      u1 (.clk(clk), .rst(rst), .bus(if1));
   vip_matrix_generate_nxn #(.DATA_W(10), .KSIZE(5), .IMG_HDISP(HD), .IMG_VDISP(VD), .PAD_MODE(0))
      u2 (.clk(clk), .rst(rst), .bus(if2));

   // Output capture, indexed by the number of rising edges seen so far.
   logic         m_vs [NCYC], m_hr [NCYC], m_ce [NCYC];
   logic [71:0]  m_d0 [NCYC], m_d1 [NCYC];
   logic [249:0] m_d2 [NCYC];
`ifdef VIP_MATRIX_FULL_FLAG_EN
   logic         m_f0 [NCYC], m_f2 [NCYC];
`endif
   always @(negedge clk) begin
      if (cyc < NCYC) begin
         m_vs[cyc] <= if0.matrix_frame_vsync;
         m_hr[cyc] <= if0.matrix_frame_href;
         m_ce[cyc] <= if0.matrix_frame_clken;
         m_d0[cyc] <= if0.matrix_data;
         m_d1[cyc] <= if1.matrix_data;
         m_d2[cyc] <= if2.matrix_data;
`ifdef VIP_MATRIX_FULL_FLAG_EN
         m_f0[cyc] <= if0.matrix_full;
         m_f2[cyc] <= if2.matrix_full;
`endif
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix8(input int mode, input int y, input int x);
      if (mode == 0) return 8'(y * 16 + x);
      if (mode == 1) return 8'hFF;
      return 8'h00;
   endfunction

   function automatic logic [9:0] pix10(input int mode, input int y, input int x);
      if (mode == 0) return 10'(y * 32 + x);
      if (mode == 1) return 10'h3FF;
      return 10'h000;
   endfunction

   task automatic step(input logic vs, input logic hr, input logic ce,
                       input logic [7:0] d8, input logic [9:0] d10);
      if0.pre_frame_vsync = vs; if0.pre_frame_href = hr; if0.pre_frame_clken = ce; if0.pre_img_data = d8;
      if1.pre_frame_vsync = vs; if1.pre_frame_href = hr; if1.pre_frame_clken = ce; if1.pre_img_data = d8;
      if2.pre_frame_vsync = vs; if2.pre_frame_href = hr; if2.pre_frame_clken = ce; if2.pre_img_data = d10;
      @(posedge clk);
      #1;
   endtask

   // mode 0: pixel = coordinates (with a 2-cycle clken stall in line 2); 1: all ones; 2: all zero.
   task automatic drive_frame(input int mode, input int rst_line);
      vs_cyc = cyc;
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      for (int y = 0; y < VD; y++) begin
         if (y == rst_line) begin
            rst = 1'b1;
            step(0, 0, 0, 0, 0);
            rst = 1'b0;
         end
         for (int x = 0; x < HD; x++) begin
            if (mode == 0 && y == 2 && x == 5) begin
               st0 = cyc; step(0, 1, 0, 0, 0);
               st1 = cyc; step(0, 1, 0, 0, 0);
            end
            pc[y][x] = cyc;
            step(0, 1, 1, pix8(mode, y, x), pix10(mode, y, x));
         end
         repeat (4) step(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      logic [249:0] e5;
      repeat (3) step(0, 0, 0, 0, 0);
      chk("rst_vsync", if0.matrix_frame_vsync, 1'b0);
      chk("rst_href",  if0.matrix_frame_href,  1'b0);
      chk("rst_clken", if0.matrix_frame_clken, 1'b0);
      chk("rst_data0", if0.matrix_data, 72'h0);
      chk("rst_data2", if2.matrix_data, 250'h0);
`ifdef VIP_MATRIX_FULL_FLAG_EN
      chk("rst_full", if0.matrix_full, 1'b0);
`endif
      rst = 1'b0;

      drive_frame(0, -1);
      chk("vsync_lat2", m_vs[vs_cyc+2], 1'b0);
      chk("vsync_lat3", m_vs[vs_cyc+3], 1'b1);
      chk("p00_clken",  m_ce[pc[0][0]+3], 1'b1);
      chk("p00_data",   m_d0[pc[0][0]+3], 72'h0);
      chk("p23_zero",   m_d0[pc[2][3]+3], 72'h232221_131211_030201);
      chk("p27_zero",   m_d0[pc[2][7]+3], 72'h272625_171615_070605);
      chk("p50_zero",   m_d0[pc[5][0]+3], 72'h500000_400000_300000);
      chk("p01_rep",    m_d1[pc[0][1]+3], 72'h010000_010000_010000);
      chk("p10_rep",    m_d1[pc[1][0]+3], 72'h101010_000000_000000);
      chk("gap_href",   m_hr[pc[0][7]+4], 1'b0);
      chk("gap_data",   m_d0[pc[0][7]+4], 72'h0);
      chk("stall_pre_ce",  m_ce[pc[2][4]+3], 1'b1);
      chk("stall0_ce",     m_ce[st0+3], 1'b0);
      chk("stall1_ce",     m_ce[st1+3], 1'b0);
      chk("stall_href",    m_hr[st0+3], 1'b1);
      chk("stall_hold",    m_d0[st1+3], 72'h242322_141312_040302);
      chk("stall_post_ce", m_ce[pc[2][5]+3], 1'b1);
      chk("stall_post",    m_d0[pc[2][5]+3], 72'h252423_151413_050403);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            e5[(r*5+c)*10 +: 10] = 10'(r * 32 + c);
      chk("k5_p44",      m_d2[pc[4][4]+3], e5);
      chk("k5_p43_e00",  m_d2[pc[4][3]+3][9:0], 10'h000);
      chk("k5_p43_e44",  m_d2[pc[4][3]+3][249:240], 10'h083);
`ifdef VIP_MATRIX_FULL_FLAG_EN
      chk("full_k5_p44", m_f2[pc[4][4]+3], 1'b1);
      chk("full_k5_p43", m_f2[pc[4][3]+3], 1'b0);
      chk("full_k3_p22", m_f0[pc[2][2]+3], 1'b1);
      chk("full_k3_p21", m_f0[pc[2][1]+3], 1'b0);
      chk("full_k3_p12", m_f0[pc[1][2]+3], 1'b0);
`endif

      drive_frame(1, -1);
      drive_frame(1, -1);
      chk("ff_p11_zero", m_d0[pc[1][1]+3], 72'hFFFF00_FFFF00_000000);

      drive_frame(2, -1);
      for (int x = 0; x < HD; x++) begin
         chk($sformatf("stale_zero_x%0d", x), m_d0[pc[0][x]+3], 72'h0);
         chk($sformatf("stale_rep_x%0d", x),  m_d1[pc[0][x]+3], 72'h0);
      end

      drive_frame(0, 3);
      chk("rstline_p32_zero", m_d0[pc[3][2]+3], 72'h323130_000000_000000);
      chk("rstline_p35_zero", m_d0[pc[3][5]+3], 72'h353433_000000_000000);
      chk("rstline_p32_rep",  m_d1[pc[3][2]+3], 72'h323130_323130_323130);
      chk("rstline_p30_rep",  m_d1[pc[3][0]+3], 72'h303030_303030_303030);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
